// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit processor: opcode encodings, the
// opcode legality check and the fetch-stage state encoding.
package cpu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b100;
    localparam logic [2:0] OP_SW   = 3'b101;
    localparam logic [2:0] OP_LW   = 3'b110;
    localparam logic [2:0] OP_SLL  = 3'b111;

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_DELIVER
    } fetch_state_t;

    // True for the five implemented opcodes; 001/010/011 are unassigned.
    function automatic logic is_legal_op(input logic [2:0] op);
        case (op)
            OP_ADD, OP_ADDI, OP_SW, OP_LW, OP_SLL: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter register: wraps modulo 2^PC_WIDTH, load beats increment.
module program_counter
    import cpu_pkg::*;
#(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc,
    input  logic                load,
    input  logic [PC_WIDTH-1:0] load_value,
    output logic [PC_WIDTH-1:0] pc
);

    // Redirect wins over sequential advance; the add wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc <= RESET_PC;
        else if (load)
            pc <= load_value;
        else if (inc)
            pc <= pc + 1'b1;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: requests one word per fetch from instruction
// memory, holds it in the instruction register until the consumer takes
// it, and supports PC redirect (flush) with priority over everything else.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [7:0]          imem_rdata,
    input  logic                imem_valid,
    input  logic                stall,
    input  logic                flush,
    input  logic [PC_WIDTH-1:0] flush_pc,
    output logic [7:0]          instr,
    output logic [2:0]          opcode,
    output logic                instr_valid,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic                illegal_op
);

    fetch_state_t        state;
    logic [PC_WIDTH-1:0] pc;
    logic                redirect;
    logic                capture;
    logic                accept;

    // Flush is meaningless before the first fetch, so BOOT ignores it.
    assign redirect = flush && (state != S_BOOT);
    assign capture  = (state == S_FETCH) && imem_valid && !flush;
    assign accept   = (state == S_DELIVER) && instr_valid && !stall && !flush;

    program_counter #(
        .PC_WIDTH (PC_WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc        (capture),
        .load       (redirect),
        .load_value (flush_pc),
        .pc         (pc)
    );

    assign imem_addr = pc;
    assign opcode    = instr[7:5];

    // Fetch sequencer; imem_req is registered with the state so it drops
    // the instant reset asserts and never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_BOOT;
            imem_req <= 1'b0;
        end else begin
            case (state)
                S_BOOT: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                end
                S_FETCH: begin
                    if (capture) begin
                        state    <= S_DELIVER;
                        imem_req <= 1'b0;
                    end
                end
                S_DELIVER: begin
                    if (redirect || accept) begin
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                    end
                end
                default: begin
                    state    <= S_BOOT;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    // Instruction register with its fetch address and legality flag; the
    // flag is only ever set together with instr_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr       <= 8'h00;
            pc_out      <= RESET_PC;
            instr_valid <= 1'b0;
            illegal_op  <= 1'b0;
        end else if (redirect) begin
            instr_valid <= 1'b0;
            illegal_op  <= 1'b0;
        end else if (capture) begin
            instr       <= imem_rdata;
            pc_out      <= pc;
            instr_valid <= 1'b1;
            illegal_op  <= !is_legal_op(imem_rdata[7:5]);
        end else if (accept) begin
            instr_valid <= 1'b0;
            illegal_op  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by random traffic,
// all compared each cycle against a transaction-level reference model.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic [7:0] imem_rdata;
    logic       imem_valid;
    logic       stall;
    logic       flush;
    logic [7:0] flush_pc;
    logic [7:0] instr;
    logic [2:0] opcode;
    logic       instr_valid;
    logic [7:0] pc_out;
    logic       illegal_op;

    fetch_unit #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .stall       (stall),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .instr       (instr),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .pc_out      (pc_out),
        .illegal_op  (illegal_op)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] mem [256];

    // Reference model: "booting" covers the one dead cycle after reset,
    // "want_word" means a fetch is outstanding, "holding" a word is presented.
    bit       m_booting;
    bit       m_want_word;
    int       m_pc;
    int       m_instr;
    int       m_pc_out;
    bit       m_holding;

    task automatic model_reset();
        m_booting   = 1;
        m_want_word = 0;
        m_pc        = 0;
        m_instr     = 0;
        m_pc_out    = 0;
        m_holding   = 0;
    endtask

    task automatic model_edge(input bit v, input bit st, input bit fl, input int fpc, input int word);
        if (m_booting) begin
            m_booting   = 0;
            m_want_word = 1;
        end else if (fl) begin
            m_pc        = fpc;
            m_holding   = 0;
            m_want_word = 1;
        end else if (m_want_word && v) begin
            m_instr     = word;
            m_pc_out    = m_pc;
            m_pc        = (m_pc + 1) % 256;
            m_holding   = 1;
            m_want_word = 0;
        end else if (m_holding && !st) begin
            m_holding   = 0;
            m_want_word = 1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int op;
        bit ill;
        op  = m_instr / 32;
        ill = m_holding && (op >= 1) && (op <= 3);
        check("imem_req",    8'(imem_req),    8'(m_want_word && !m_booting));
        check("imem_addr",   imem_addr,       8'(m_pc));
        check("instr",       instr,           8'(m_instr));
        check("opcode",      8'(opcode),      8'(op));
        check("instr_valid", 8'(instr_valid), 8'(m_holding));
        check("pc_out",      pc_out,          8'(m_pc_out));
        check("illegal_op",  8'(illegal_op),  8'(ill));
    endtask

    // One clock: drive inputs, let the edge happen, advance model, compare.
    task automatic step(input bit v, input bit st, input bit fl, input logic [7:0] fpc);
        logic [7:0] word;
        word       = v ? mem[m_pc] : 8'($urandom);
        imem_valid = v;
        stall      = st;
        flush      = fl;
        flush_pc   = fpc;
        imem_rdata = word;
        @(posedge clk);
        model_edge(v, st, fl, int'(fpc), int'(word));
        #1;
        check_all();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h00] = 8'h83;
        mem[8'h02] = 8'hC1;
        mem[8'h40] = 8'h2A;

        rst_n = 1'b0; imem_valid = 0; stall = 0; flush = 0;
        flush_pc = 8'h00; imem_rdata = 8'h00;
        model_reset();
        #12;
        check_all();
        rst_n = 1'b1;

        // boot cycle, then zero-wait fetch of 8'h83
        step(0, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        // accept, then a fetch with three wait cycles
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        // fetch 8'hC1 and hold it under stall for five cycles
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        // redirect to 8'hFF, fetch, accept: next address wraps to 0
        step(0, 0, 1, 8'hFF);
        step(1, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        // flush to 8'h40 coincident with valid and stall: no capture
        step(1, 1, 1, 8'h40);
        // illegal word 8'h2A, held under stall, then accepted
        step(1, 0, 0, 8'h00);
        step(0, 1, 0, 8'h00);
        step(0, 1, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        // reset pulse while a fetch is waiting
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        #2;
        rst_n = 1'b1;

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 2) != 0),
                 bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 15) == 0),
                 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
